opc_ext_bus_ctrl: RTL
=====================

// Module: opc_ext_bus_ctrl
// PURPOSE
//   External memory bus sequencer/arbiter for the OPC CPU on the pin-limited tile.
//   Shares one external SRAM port between the CPU and a debug/loader requester.
//   Time-multiplexes the 11-bit address over 8 address pins (high bits latched
//   externally on ALE), then runs a read or write strobe of programmable length.
// PARAMETERS
//   WAIT_CYCLES  2  strobe length in clk cycles (legal 1..15; 4-bit counter)
// PORTS
//   clk          in   1   clock
//   rst_n        in   1   asynchronous, active-low reset
//   cpu_req      in   1   CPU access request (level, held until cpu_ack)
//   cpu_rnw      in   1   1=read, 0=write
//   cpu_addr     in   11  CPU address
//   cpu_wdata    in   8   CPU write data
//   cpu_ack      out  1   1-cycle completion pulse to CPU
//   dbg_req      in   1   debug/loader request (level, held until dbg_ack)
//   dbg_rnw      in   1   1=read, 0=write
//   dbg_addr     in   11  debug address
//   dbg_wdata    in   8   debug write data
//   dbg_ack      out  1   1-cycle completion pulse to debug port
//   rdata        out  8   read data; valid in ack cycle, held until next read capture
//   busy         out  1   1 whenever state != IDLE
//   ext_a        out  8   address pins (high part in ADDR_HI, low byte in STROBE)
//   ext_ale      out  1   address-high latch enable
//   ext_oe_n     out  1   SRAM output enable, active low
//   ext_we_n     out  1   SRAM write enable, active low
//   ext_d_in     in   8   data pins, input path
//   ext_d_out    out  8   data pins, output path
//   ext_d_oe     out  8   data pin output enables (1=drive)
// BEHAVIOUR
//   Reset: state=IDLE, last_grant=DBG, cpu_ack=dbg_ack=0, rdata=0, busy=0,
//     ext_a=0, ext_ale=0, ext_oe_n=1, ext_we_n=1, ext_d_out=0, ext_d_oe=0.
//   FSM states: IDLE -> ADDR_HI -> STROBE -> DONE -> IDLE.
//   IDLE: if any req, grant and latch {rnw,addr,wdata} of winner; go ADDR_HI.
//     Only CPU req -> CPU; only dbg req -> DBG; both -> requester != last_grant
//     (round-robin; CPU wins the first tie after reset). last_grant updates on grant.
//   ADDR_HI (1 cycle): ext_a={5'b0,addr[10:8]}, ext_ale=1; load wait counter.
//   STROBE (WAIT_CYCLES cycles): ext_a=addr[7:0], ext_ale=0.
//     read:  ext_oe_n=0, ext_d_oe=8'h00; rdata <= ext_d_in at clock edge ending
//            the last STROBE cycle.
//     write: ext_we_n=0, ext_d_oe=8'hFF, ext_d_out=wdata.
//   DONE (1 cycle): strobes inactive, ext_d_oe=0; ack of granted requester =1,
//     other ack=0; ext_a holds addr[7:0]. Always returns to IDLE.
//   Latency: req sampled in cycle 0 -> ack in cycle WAIT_CYCLES+2. Next grant
//     no earlier than the cycle after DONE (one idle cycle between transactions).
//   Requester drops req in the cycle after its ack; a req still high in IDLE
//     starts a new transaction. Request inputs are ignored outside IDLE;
//     latched fields are stable for the whole transaction.
//   ext_we_n and ext_oe_n are never both 0; ext_d_oe=8'hFF only in write STROBE.
//   ext_ale is 0 in every state except ADDR_HI.
//   Address 11'h7FF: ext_a=8'h07 in ADDR_HI, 8'hFF in STROBE (no truncation).
//   Reset mid-transaction: immediate return to reset values; no ack issued,
//     rdata not updated; aborted write may be partial (acceptable).
// TESTING
//   CPU read 11'h5A3, W=2, ext_d_in=8'h3C: c1 ext_a=05 ale=1; c2-3 ext_a=A3
//     oe_n=0; c4 cpu_ack=1 rdata=3C; c5 busy=0.
//   dbg write 11'h100 data 8'h77: c1 ext_a=01 ale=1; c2-3 we_n=0 d_oe=FF
//     d_out=77; c4 dbg_ack=1, cpu_ack=0.
//   cpu_req+dbg_req held from reset for 3 transactions -> grants CPU, DBG, CPU;
//     each ack only to its own requester.
//   rst_n low during 2nd STROBE cycle of a write -> same cycle we_n=1, d_oe=0,
//     busy=0; no ack; rdata unchanged.
//   WAIT_CYCLES=1, CPU read 11'h7FF, ext_d_in=8'hA5 -> ext_a 07 then FF;
//     cpu_ack in c3 with rdata=A5.
//   Every cycle: assert !(~ext_we_n & ~ext_oe_n) and ale only in ADDR_HI.

Source files
------------

// File: rtl/opc_ext_bus_ctrl.sv
// opc_ext_bus_ctrl: shares one external SRAM port between CPU and debug requesters,
// multiplexing the 11-bit address over 8 pins (high bits on ALE) with a timed strobe.
module opc_ext_bus_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic        dbg_rnw,
  input  logic [10:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [7:0]  ext_a,
  output logic        ext_ale,
  output logic        ext_oe_n,
  output logic        ext_we_n,
  input  logic [7:0]  ext_d_in,
  output logic [7:0]  ext_d_out,
  output logic [7:0]  ext_d_oe
);
  typedef enum logic [1:0] {IDLE, ADDR_HI, STROBE, DONE} state_t;
  localparam logic [3:0] LOAD = 4'(WAIT_CYCLES - 1);
  state_t      state;
  logic        last_cpu, grant_cpu, rnw, pick_cpu;
  logic [10:0] addr, pick_addr;
  logic [7:0]  wdata;
  logic [3:0]  cnt;
  // Round-robin on a tie: the requester that did not win last time goes next.
  assign pick_cpu  = cpu_req & (~dbg_req | ~last_cpu);
  assign pick_addr = pick_cpu ? cpu_addr : dbg_addr;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      last_cpu  <= 1'b0;
      grant_cpu <= 1'b0;
      rnw       <= 1'b1;
      addr      <= '0;
      wdata     <= '0;
      cnt       <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      rdata     <= '0;
      ext_a     <= '0;
      ext_ale   <= 1'b0;
      ext_oe_n  <= 1'b1;
      ext_we_n  <= 1'b1;
      ext_d_out <= '0;
      ext_d_oe  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: if (cpu_req | dbg_req) begin
          state     <= ADDR_HI;
          grant_cpu <= pick_cpu;
          last_cpu  <= pick_cpu;
          rnw       <= pick_cpu ? cpu_rnw : dbg_rnw;
          addr      <= pick_addr;
          wdata     <= pick_cpu ? cpu_wdata : dbg_wdata;
          ext_a     <= {5'b0, pick_addr[10:8]};
          ext_ale   <= 1'b1;
        end
        ADDR_HI: begin
          state     <= STROBE;
          cnt       <= LOAD;
          ext_a     <= addr[7:0];
          ext_ale   <= 1'b0;
          ext_oe_n  <= ~rnw;
          ext_we_n  <= rnw;
          ext_d_oe  <= rnw ? 8'h00 : 8'hFF;
          ext_d_out <= rnw ? ext_d_out : wdata;
        end
        STROBE: if (cnt == 4'd0) begin
          state    <= DONE;
          rdata    <= rnw ? ext_d_in : rdata;
          ext_oe_n <= 1'b1;
          ext_we_n <= 1'b1;
          ext_d_oe <= 8'h00;
          cpu_ack  <= grant_cpu;
          dbg_ack  <= ~grant_cpu;
        end else cnt <= cnt - 4'd1;
        DONE: state <= IDLE;
      endcase
    end
endmodule
